// File: rtl/counter_pkg.sv
// Shared types and constants for the run/stop counter controller.
package counter_pkg;

  localparam int CNT_W   = 3;
  localparam int PRESC_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic state_is_busy(input state_t s);
    return (s == RUN) || (s == PAUSE);
  endfunction

endpackage

// File: rtl/counter_seq_ctrl_count3_en.sv
// Counter datapath: synchronous clear has priority over enable.
import counter_pkg::*;

module count3_en #(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Run/stop controller: prescaler, command FSM and terminal-count handling for the counter.
import counter_pkg::*;

module counter_seq_ctrl #(
  parameter int DIV   = 4,
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output state_t           state_dbg
);

  state_t               state, state_next;
  logic [PRESC_W-1:0]   presc, presc_next;
  logic [WIDTH-1:0]     lim_r;
  logic                 mode_r;
  logic                 load;
  logic                 cnt_en, cnt_clr;
  logic                 done_next, wrap_next;
  logic                 tick;

  // A tick is only ever taken while running; PAUSE time never advances the prescaler.
  assign tick = (state == RUN) && (presc == PRESC_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      presc  <= '0;
      lim_r  <= '0;
      mode_r <= 1'b0;
      done   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      state <= state_next;
      presc <= presc_next;
      done  <= done_next;
      wrap  <= wrap_next;
      if (load) begin
        lim_r  <= limit;
        mode_r <= mode;
      end
    end
  end

  always_comb begin
    state_next = state;
    presc_next = presc;
    load       = 1'b0;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    done_next  = 1'b0;
    wrap_next  = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          cnt_clr = 1'b1;
        end else if (start) begin
          state_next = RUN;
          presc_next = '0;
          load       = 1'b1;
          cnt_clr    = 1'b1;
        end
      end
      RUN: begin
        if (clear) begin
          state_next = IDLE;
          presc_next = '0;
          cnt_clr    = 1'b1;
        end else if (stop) begin
          state_next = PAUSE;
        end else if (tick) begin
          presc_next = '0;
          if (q != lim_r) begin
            cnt_en = 1'b1;
          end else if (!mode_r) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            cnt_clr   = 1'b1;
            wrap_next = 1'b1;
          end
        end else begin
          presc_next = presc + PRESC_W'(1);
        end
      end
      PAUSE: begin
        // Resume keeps the frozen prescaler so a partial tick is not lost.
        if (clear) begin
          state_next = IDLE;
          presc_next = '0;
          cnt_clr    = 1'b1;
        end else if (start) begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (clear) begin
          state_next = IDLE;
          presc_next = '0;
          cnt_clr    = 1'b1;
        end else if (start) begin
          state_next = RUN;
          presc_next = '0;
          load       = 1'b1;
          cnt_clr    = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        presc_next = '0;
        cnt_clr    = 1'b1;
      end
    endcase
  end

  count3_en #(.WIDTH(WIDTH)) u_count (
    .clk  (clk),
    .rstn (rstn),
    .en   (cnt_en),
    .clr  (cnt_clr),
    .q    (q)
  );

  assign busy      = state_is_busy(state);
  assign state_dbg = state;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed self-checking bench for counter_seq_ctrl with DIV=4, WIDTH=3.
import counter_pkg::*;

module tb_counter_seq_ctrl;

  logic       clk;
  logic       rstn;
  logic       start, stop, clear, mode;
  logic [2:0] limit;
  logic [2:0] q;
  logic       busy, done, wrap;
  state_t     state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  counter_seq_ctrl #(.DIV(4), .WIDTH(3)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .mode      (mode),
    .limit     (limit),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input state_t st, input logic [2:0] q_exp,
                           input logic done_exp, input logic wrap_exp);
    logic busy_exp;
    busy_exp = (st == RUN) || (st == PAUSE);
    check({tag, ".state"}, 32'(state_dbg), 32'(st));
    check({tag, ".q"},     32'(q),         32'(q_exp));
    check({tag, ".busy"},  32'(busy),      32'(busy_exp));
    check({tag, ".done"},  32'(done),      32'(done_exp));
    check({tag, ".wrap"},  32'(wrap),      32'(wrap_exp));
  endtask

  // Driver: pulse start for one edge with the given limit/mode.
  task automatic do_start(input logic [2:0] lim, input logic md);
    limit = lim;
    mode  = md;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  logic [2:0] ar_q [6];

  initial begin
    rstn = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; mode = 1'b0; limit = 3'd0;
    ar_q = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};

    // 1. Reset in IDLE, with start held to show reset wins
    start = 1'b1;
    step(2);
    check_all("rst_idle", IDLE, 3'd0, 1'b0, 1'b0);
    start = 1'b0;
    rstn  = 1'b1;
    step(1);
    check_all("rst_idle_rel", IDLE, 3'd0, 1'b0, 1'b0);

    // Reset in RUN
    do_start(3'd7, 1'b0);
    step(6);
    check_all("rst_run_pre", RUN, 3'd1, 1'b0, 1'b0);
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
    step(1);
    check_all("rst_run", IDLE, 3'd0, 1'b0, 1'b0);

    // Reset in PAUSE
    do_start(3'd7, 1'b0);
    step(5);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check_all("rst_pause_pre", PAUSE, 3'd1, 1'b0, 1'b0);
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
    step(1);
    check_all("rst_pause", IDLE, 3'd0, 1'b0, 1'b0);

    // 2. One-shot, limit=3; changing limit mid-run must not matter
    do_start(3'd3, 1'b0);
    limit = 3'd5;
    check_all("os_k", RUN, 3'd0, 1'b0, 1'b0);
    step(3);
    check_all("os_k3", RUN, 3'd0, 1'b0, 1'b0);
    step(1);
    check_all("os_k4", RUN, 3'd1, 1'b0, 1'b0);
    step(4);
    check_all("os_k8", RUN, 3'd2, 1'b0, 1'b0);
    step(4);
    check_all("os_k12", RUN, 3'd3, 1'b0, 1'b0);
    step(3);
    check_all("os_k15", RUN, 3'd3, 1'b0, 1'b0);
    step(1);
    check_all("os_k16", DONE, 3'd3, 1'b1, 1'b0);
    step(1);
    check_all("os_k17", DONE, 3'd3, 1'b0, 1'b0);
    step(3);
    check_all("os_hold", DONE, 3'd3, 1'b0, 1'b0);
    do_clear();
    check_all("os_clear", IDLE, 3'd0, 1'b0, 1'b0);

    // 3. Auto-reload, limit=2
    do_start(3'd2, 1'b1);
    mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(3);
      check_all($sformatf("ar_pre%0d", i), RUN, (i == 0) ? 3'd0 : ar_q[i-1], 1'b0, 1'b0);
      step(1);
      check_all($sformatf("ar_tick%0d", i), RUN, ar_q[i], 1'b0, (i == 2) || (i == 5));
    end
    do_clear();
    check_all("ar_clear", IDLE, 3'd0, 1'b0, 1'b0);

    // 4. Pause / resume: stop sampled at k+7 freezes prescaler at 2
    do_start(3'd7, 1'b0);
    step(6);
    check_all("pr_k6", RUN, 3'd1, 1'b0, 1'b0);
    stop = 1'b1;
    step(1);
    check_all("pr_k7", PAUSE, 3'd1, 1'b0, 1'b0);
    step(9);
    check_all("pr_k16", PAUSE, 3'd1, 1'b0, 1'b0);
    stop  = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    check_all("pr_resume", RUN, 3'd1, 1'b0, 1'b0);
    step(1);
    check_all("pr_r1", RUN, 3'd1, 1'b0, 1'b0);
    step(1);
    check_all("pr_r2", RUN, 3'd2, 1'b0, 1'b0);
    step(3);
    check_all("pr_r5", RUN, 3'd2, 1'b0, 1'b0);
    step(1);
    check_all("pr_r6", RUN, 3'd3, 1'b0, 1'b0);

    // start held in RUN is ignored
    start = 1'b1;
    step(4);
    check_all("hold_start_run", RUN, 3'd4, 1'b0, 1'b0);
    start = 1'b0;
    do_clear();
    check_all("pr_clear", IDLE, 3'd0, 1'b0, 1'b0);

    // 5. clear + start together in RUN at q=2
    do_start(3'd7, 1'b0);
    step(8);
    check_all("cs_k8", RUN, 3'd2, 1'b0, 1'b0);
    clear = 1'b1;
    start = 1'b1;
    step(1);
    clear = 1'b0;
    start = 1'b0;
    check_all("cs_both", IDLE, 3'd0, 1'b0, 1'b0);
    step(1);
    check_all("cs_after", IDLE, 3'd0, 1'b0, 1'b0);

    // clear on a wrap tick edge
    do_start(3'd1, 1'b1);
    step(7);
    check_all("cw_k7", RUN, 3'd1, 1'b0, 1'b0);
    do_clear();
    check_all("cw_k8", IDLE, 3'd0, 1'b0, 1'b0);
    step(1);
    check_all("cw_k9", IDLE, 3'd0, 1'b0, 1'b0);

    // clear on a one-shot terminal tick edge
    do_start(3'd0, 1'b0);
    step(3);
    do_clear();
    check_all("cd_k4", IDLE, 3'd0, 1'b0, 1'b0);

    // 6. limit=0 one-shot, then restart from DONE with limit=1
    do_start(3'd0, 1'b0);
    step(3);
    check_all("l0_k3", RUN, 3'd0, 1'b0, 1'b0);
    step(1);
    check_all("l0_k4", DONE, 3'd0, 1'b1, 1'b0);
    do_start(3'd1, 1'b0);
    check_all("rs_s", RUN, 3'd0, 1'b0, 1'b0);
    step(4);
    check_all("rs_s4", RUN, 3'd1, 1'b0, 1'b0);
    step(3);
    check_all("rs_s7", RUN, 3'd1, 1'b0, 1'b0);
    step(1);
    check_all("rs_s8", DONE, 3'd1, 1'b1, 1'b0);

    // start held in DONE restarts at once
    start = 1'b1;
    step(1);
    check_all("hold_start_done", RUN, 3'd0, 1'b0, 1'b0);
    start = 1'b0;
    do_clear();

    // limit=0 auto-reload: wrap every 4 cycles, q stays 0
    do_start(3'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(3);
      check_all($sformatf("l0ar_pre%0d", i), RUN, 3'd0, 1'b0, 1'b0);
      step(1);
      check_all($sformatf("l0ar_tick%0d", i), RUN, 3'd0, 1'b0, 1'b1);
    end
    do_clear();
    check_all("l0ar_clear", IDLE, 3'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Run/stop controller for the lab's 3-bit up-counter datapath. It prescales the system clock into count ticks, starts, pauses, resumes and clears the counter. It stops the count at a programmable terminal value (one-shot) or wraps back to zero (auto-reload). It is the block board-level logic (buttons, LEDs, seven-segment) talks to instead of driving the counter directly.

## Interface
- `DIV`, default 4: clocks per count tick; legal range 2..255.
- `WIDTH`, default 3: counter width; the bench covers only 3.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rstn` input 1: reset, synchronous, active-low.
- `start` input 1: level-sampled command; begin from IDLE/DONE, or resume from PAUSE.
- `stop` input 1: pause the count.
- `clear` input 1: abort the run and return to IDLE.
- `mode` input 1: 0 = one-shot, 1 = auto-reload; sampled on a start from IDLE/DONE.
- `limit` input WIDTH: terminal count; sampled into `lim_r` on a start from IDLE/DONE.
- `q` output WIDTH: counter value.
- `busy` output 1: high in RUN and PAUSE.
- `done` output 1: one-cycle pulse when a one-shot run ends.
- `wrap` output 1: one-cycle pulse when an auto-reload run wraps.

## Operation
- **States:** IDLE, RUN, PAUSE, DONE, encoded in 2 bits.
- **Command priority:** each edge acts on at most one command, in the order `clear` > `stop` > `start`.
- **Reset** (`rstn`=0 at an edge):
  - state = IDLE.
  - q = 0, prescaler = 0, `lim_r` = 0, `mode_r` = 0.
  - `busy` = `done` = `wrap` = 0.
  - Reset overrides every command and any in-flight run.
- **IDLE:**
  - q = 0.
  - `start` → RUN; prescaler = 0; `lim_r` ← `limit`; `mode_r` ← `mode`.
  - `stop` is ignored.
- **RUN:**
  - The prescaler counts 0..DIV-1. A tick occurs on the edge where prescaler == DIV-1; the prescaler then returns to 0.
  - On a tick with q != `lim_r`: q ← q+1.
  - On a tick with q == `lim_r` and `mode_r`=0: go to DONE; q holds; `done`=1 for the next cycle.
  - On a tick with q == `lim_r` and `mode_r`=1: q ← 0; stay in RUN; `wrap`=1 for the next cycle.
  - `stop` → PAUSE; prescaler and q freeze; no tick is taken on that edge.
  - `clear` → IDLE; q ← 0.
  - `start` is ignored.
- **PAUSE:**
  - `start` → RUN; the prescaler resumes from its frozen value; `lim_r` and `mode_r` are unchanged.
  - `clear` → IDLE.
  - `stop` is ignored.
- **DONE:**
  - q holds `lim_r`; `busy`=0.
  - `start` → RUN with q ← 0, prescaler ← 0, and `limit`/`mode` resampled.
  - `clear` → IDLE.
- **Arithmetic:** q is unsigned WIDTH bits and never exceeds `lim_r`.
- **limit = 0:**
  - one-shot: DONE on the first tick.
  - auto-reload: `wrap` pulses every DIV cycles while q stays 0.
- **Command timing:** commands are level-sampled every edge. Holding `start` in RUN has no effect. Holding `start` in DONE restarts a run immediately.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Let k be the edge that samples `start` in IDLE. Then:
  - RUN is active from edge k.
  - q = 1 after edge k+DIV.
  - q = n after edge k+n·DIV.
- **One-shot end:** the DONE transition happens on edge k+(lim+1)·DIV. `done` is high from that edge to the next one.
- **Auto-reload:** `wrap` pulses at edges k+(lim+1)·DIV·m, for m = 1, 2, …
- **Command response:** `busy` follows state with one edge of latency from the command.
- **Pause accounting:** time spent in PAUSE does not count toward a tick.
- **Simultaneous events:** if `clear` arrives on the same edge as a tick, `clear` wins; no `done` or `wrap` pulse is produced.

## Structure
- Shared package `counter_pkg` holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - the constant `CNT_W` = 3.
- One sub-module, `count3_en`: the counter datapath with `en`, synchronous `clr`, and a parallel `q`.
  - The controller drives `en` as the tick qualifier and `clr` on clear/restart/wrap.
- The prescaler and FSM stay in `counter_seq_ctrl`.

## Test plan
Unless stated otherwise, DIV=4, with `start` sampled at edge k.
1. **Reset:** hold `rstn`=0 for 2 cycles in each of IDLE, RUN and PAUSE → on the next edge q=0, `busy`=0, `done`=0, `wrap`=0, state IDLE.
2. **One-shot:** `limit`=3, `mode`=0, `start` at edge k → q = 1, 2, 3 at k+4, k+8, k+12; `done` pulses one cycle at k+16; q stays 3; `busy`=0.
3. **Auto-reload:** `limit`=2, `mode`=1 → q sequence 1, 2, 0, 1, 2, 0; `wrap` pulses at k+12 and k+24; `busy` stays 1; `done` never pulses.
4. **Pause/resume:** `stop` at k+6 (q=1, prescaler=2), held for 10 cycles, then `start` → q=2 appears 2 cycles after resume; later ticks are shifted by exactly the pause length.
5. **Clear:** `clear` and `start` together in RUN at q=2 → IDLE, q=0, `busy`=0, no pulse. `clear` on a tick edge → no `done`/`wrap`.
6. **limit=0 and restart:**
   - one-shot: `done` at k+4.
   - `start` while in DONE with `limit`=1 → q=0 then q=1 four cycles later, `done` at +8.
   - `start` held in RUN → ignored.
